// File: rtl/reloj_pkg.sv
// reloj_pkg: shared types and constants for the digital clock controller.
//   estado_t      : mode FSM encoding (RUN=0, SET_HH=1, SET_MM=2)
//   W_*           : widths of the hours/minutes/seconds fields
//   MAX_*         : wrap value of each field
//   inc_wrap      : increment with wrap to zero at a given maximum
package reloj_pkg;

  localparam int W_HORAS    = 5;
  localparam int W_MINUTOS  = 6;
  localparam int W_SEGUNDOS = 6;

  localparam logic [W_HORAS-1:0]    MAX_HORAS    = 5'd23;
  localparam logic [W_MINUTOS-1:0]  MAX_MINUTOS  = 6'd59;
  localparam logic [W_SEGUNDOS-1:0] MAX_SEGUNDOS = 6'd59;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2
  } estado_t;

  // Minutes and seconds share a width, so one helper serves both.
  function automatic logic [5:0] inc_wrap(input logic [5:0] val, input logic [5:0] max);
    return (val == max) ? 6'd0 : val + 6'd1;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// antirrebote: button conditioner.
//   Raw asynchronous button -> 2-flop synchronizer -> debouncer -> one-cycle
//   pulse on each accepted rising level. A held button gives one pulse only.
// Ports:
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_btn    : raw button level, active-high, asynchronous
//   o_pulse  : registered one-clk-wide pulse per accepted press
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable samples before a new level is accepted
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_estable;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_estable <= 1'b0;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      if (r_sync2 != r_estable) begin
        // The synchronized level must differ from the accepted level for
        // DEBOUNCE_CYCLES consecutive samples; the pulse fires on the sample
        // that accepts a new high level.
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_estable <= r_sync2;
          r_cnt     <= '0;
          r_pulse   <= r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        // Any sample agreeing with the accepted level restarts the count.
        r_cnt <= '0;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/control_reloj.sv
// control_reloj: time-keeping and time-setting controller of the digital clock.
//   Counts hh:mm:ss on the 1 Hz tick, and runs the RUN -> SET_HH -> SET_MM
//   mode FSM driven by two conditioned push-buttons.
// Ports:
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   tick_1hz  : one-clk pulse per second
//   btn_mode  : raw mode button (active-high, asynchronous)
//   btn_inc   : raw increment button (active-high, asynchronous)
//   hours     : 0..23
//   minutes   : 0..59
//   seconds   : 0..59
//   mode      : FSM state (RUN=0, SET_HH=1, SET_MM=2); doubles as state debug
//   blank_hh  : hours field blanked (blink)
//   blank_mm  : minutes field blanked (blink)
// Configuration:
//   CONTROL_RELOJ_BLINK_EN : when defined, builds the blink-phase flop that
//   drives blank_hh/blank_mm in the set states; otherwise both are tied to 0.
module control_reloj
  import reloj_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_1hz,
  input  logic                  btn_mode,
  input  logic                  btn_inc,
  output logic [W_HORAS-1:0]    hours,
  output logic [W_MINUTOS-1:0]  minutes,
  output logic [W_SEGUNDOS-1:0] seconds,
  output logic [1:0]            mode,
  output logic                  blank_hh,
  output logic                  blank_mm
);

  logic w_p_mode;
  logic w_p_inc;

  estado_t                 r_estado;
  logic [W_HORAS-1:0]      r_horas;
  logic [W_MINUTOS-1:0]    r_minutos;
  logic [W_SEGUNDOS-1:0]   r_segundos;

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_mode (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_btn   (btn_mode),
    .o_pulse (w_p_mode)
  );

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_inc (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_btn   (btn_inc),
    .o_pulse (w_p_inc)
  );

  // Mode FSM and time registers. A mode pulse always takes priority over an
  // inc pulse in the same cycle, so the inc is simply dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado   <= RUN;
      r_horas    <= '0;
      r_minutos  <= '0;
      r_segundos <= '0;
    end else begin
      case (r_estado)
        RUN: begin
          // A tick coinciding with a mode pulse is still applied; the
          // seconds clear happens on the first SET_HH cycle.
          if (tick_1hz) begin
            if (r_segundos == MAX_SEGUNDOS) begin
              r_segundos <= '0;
              if (r_minutos == MAX_MINUTOS) begin
                r_minutos <= '0;
                r_horas   <= (r_horas == MAX_HORAS) ? '0 : r_horas + 1'b1;
              end else begin
                r_minutos <= r_minutos + 1'b1;
              end
            end else begin
              r_segundos <= r_segundos + 1'b1;
            end
          end
          if (w_p_mode) r_estado <= SET_HH;
        end
        SET_HH: begin
          r_segundos <= '0;
          if (w_p_mode) begin
            r_estado <= SET_MM;
          end else if (w_p_inc) begin
            r_horas <= (r_horas == MAX_HORAS) ? '0 : r_horas + 1'b1;
          end
        end
        SET_MM: begin
          if (w_p_mode) begin
            r_estado <= RUN;
          end else if (w_p_inc) begin
            r_minutos <= inc_wrap(r_minutos, MAX_MINUTOS);
          end
        end
        default: r_estado <= RUN;
      endcase
    end
  end

  assign hours   = r_horas;
  assign minutes = r_minutos;
  assign seconds = r_segundos;
  assign mode    = r_estado;

`ifdef CONTROL_RELOJ_BLINK_EN
  logic r_fase;
  logic r_blank_hh;
  logic r_blank_mm;

  // The blank outputs are registered copies of (state & next phase), so they
  // track the phase flop without a combinational output path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fase     <= 1'b0;
      r_blank_hh <= 1'b0;
      r_blank_mm <= 1'b0;
    end else if (w_p_mode) begin
      // Every state change restarts the phase so the field shows at once.
      r_fase     <= 1'b0;
      r_blank_hh <= 1'b0;
      r_blank_mm <= 1'b0;
    end else if (tick_1hz) begin
      r_fase     <= ~r_fase;
      r_blank_hh <= (r_estado == SET_HH) & ~r_fase;
      r_blank_mm <= (r_estado == SET_MM) & ~r_fase;
    end else begin
      r_blank_hh <= (r_estado == SET_HH) & r_fase;
      r_blank_mm <= (r_estado == SET_MM) & r_fase;
    end
  end

  assign blank_hh = r_blank_hh;
  assign blank_mm = r_blank_mm;
`else
  assign blank_hh = 1'b0;
  assign blank_mm = 1'b0;
`endif

endmodule

// File: tb/tb_control_reloj.sv
module tb_control_reloj;

  localparam int W = 21;  // {mode, hours, minutes, seconds, blank_hh, blank_mm}

`ifdef CONTROL_RELOJ_BLINK_EN
  localparam logic BL = 1'b1;
`else
  localparam logic BL = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blank_hh;
  logic       blank_mm;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total;
  int           bad;

  control_reloj #(.DEBOUNCE_CYCLES(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_1hz (tick_1hz),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds),
    .mode     (mode),
    .blank_hh (blank_hh),
    .blank_mm (blank_mm)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor: drains every expectation queued since the last
  // falling edge and compares it against the outputs at that edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {mode, hours, minutes, seconds, blank_hh, blank_mm};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got mode=%0d %0d:%0d:%0d bh=%0b bm=%0b, want mode=%0d %0d:%0d:%0d bh=%0b bm=%0b",
                 n, a[20:19], a[18:14], a[13:8], a[7:2], a[1], a[0],
                 e[20:19], e[18:14], e[13:8], e[7:2], e[1], e[0]);
      end
    end
  end

  // driver tasks; each returns 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      tick_1hz = 1'b1;
      step(1);
      tick_1hz = 1'b0;
      step(2);
    end
  endtask

  task automatic press(input logic m, input logic i, input int hold);
    btn_mode = m;
    btn_inc  = i;
    step(hold);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(24);
  endtask

  task automatic press_n(input logic m, input logic i, input int n);
    repeat (n) press(m, i, 20);
  endtask

  task automatic chk(input string n, input logic [1:0] m, input logic [4:0] h,
                     input logic [5:0] mi, input logic [5:0] s,
                     input logic bh, input logic bm);
    exp_q.push_back({m, h, mi, s, bh, bm});
    name_q.push_back(n);
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(3);
    tick_1hz = 1'b1;  // ticks while in reset must not count
    step(2);
    tick_1hz = 1'b0;
    chk("reset_values", 2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    reset = 1'b1;
    step(2);

    // counting and seconds -> minutes carry
    do_tick(1);
    chk("first_tick", 2'd0, 5'd0, 6'd0, 6'd1, 1'b0, 1'b0);
    do_tick(58);
    chk("sec_59", 2'd0, 5'd0, 6'd0, 6'd59, 1'b0, 1'b0);
    do_tick(1);
    chk("sec_wrap_min_carry", 2'd0, 5'd0, 6'd1, 6'd0, 1'b0, 1'b0);
    do_tick(5);
    chk("run_more", 2'd0, 5'd0, 6'd1, 6'd5, 1'b0, 1'b0);

    // SET_HH entry clears seconds, inc ignored in RUN first
    press_n(1'b0, 1'b1, 2);
    chk("inc_ignored_run", 2'd0, 5'd0, 6'd1, 6'd5, 1'b0, 1'b0);
    press(1'b1, 1'b0, 20);
    chk("enter_set_hh", 2'd1, 5'd0, 6'd1, 6'd0, 1'b0, 1'b0);
    press_n(1'b0, 1'b1, 25);
    chk("hours_25_mod_24", 2'd1, 5'd1, 6'd1, 6'd0, 1'b0, 1'b0);
    do_tick(2);
    chk("frozen_set_hh", 2'd1, 5'd1, 6'd1, 6'd0, 1'b0, 1'b0);

    // glitch rejection and held button
    press(1'b0, 1'b1, 10);
    chk("glitch_rejected", 2'd1, 5'd1, 6'd1, 6'd0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 200);
    chk("held_one_inc", 2'd1, 5'd2, 6'd1, 6'd0, 1'b0, 1'b0);

    // mode and inc in the same cycle: mode wins
    press(1'b1, 1'b1, 20);
    chk("mode_beats_inc", 2'd2, 5'd2, 6'd1, 6'd0, 1'b0, 1'b0);

    // blink phase in SET_MM
    do_tick(1);
    chk("blink_t1", 2'd2, 5'd2, 6'd1, 6'd0, 1'b0, BL);
    do_tick(1);
    chk("blink_t2", 2'd2, 5'd2, 6'd1, 6'd0, 1'b0, 1'b0);
    do_tick(1);
    chk("blink_t3", 2'd2, 5'd2, 6'd1, 6'd0, 1'b0, BL);

    // minutes 1 -> 59 in SET_MM, no carry on wrap tested later
    press_n(1'b0, 1'b1, 58);
    chk("minutes_59", 2'd2, 5'd2, 6'd59, 6'd0, 1'b0, BL);
    press(1'b1, 1'b0, 20);
    chk("back_to_run", 2'd0, 5'd2, 6'd59, 6'd0, 1'b0, 1'b0);
    step(10);
    chk("sec_held_until_tick", 2'd0, 5'd2, 6'd59, 6'd0, 1'b0, 1'b0);

    // preload 23:59 via set path
    press(1'b1, 1'b0, 20);
    press_n(1'b0, 1'b1, 21);
    chk("hours_23", 2'd1, 5'd23, 6'd59, 6'd0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 20);
    press(1'b1, 1'b0, 20);
    chk("preload_2359", 2'd0, 5'd23, 6'd59, 6'd0, 1'b0, 1'b0);
    do_tick(59);
    chk("at_235959", 2'd0, 5'd23, 6'd59, 6'd59, 1'b0, 1'b0);
    do_tick(1);
    chk("midnight_wrap", 2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);

    // minute wrap in SET_MM does not carry into hours
    press(1'b1, 1'b0, 20);
    press_n(1'b0, 1'b1, 3);
    press(1'b1, 1'b0, 20);
    chk("set_mm_entry", 2'd2, 5'd3, 6'd0, 6'd0, 1'b0, 1'b0);
    press_n(1'b0, 1'b1, 1);
    chk("set_mm_inc", 2'd2, 5'd3, 6'd1, 6'd0, 1'b0, 1'b0);

    // asynchronous reset mid-SET_MM, no rising edge before the check
    reset = 1'b0;
    exp_q.push_back({2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0});
    name_q.push_back("async_reset");
    @(negedge clk);
    #1;
    step(3);
    reset = 1'b1;
    step(2);
    chk("after_reset", 2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);

    step(2);
    if (exp_q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_reloj.md
# control_reloj

Time-keeping and time-setting controller for the digital clock. Consumes the 1 Hz enable pulse from the count divider, maintains the hours:minutes:seconds registers, and runs the mode state machine that lets the user set hours and minutes with two push-buttons. Its outputs feed the BCD/7-segment display path directly.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable `clk` samples required before a button level is accepted.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- tick_1hz  input  1  one-`clk`-wide pulse, once per second, from the divider
- btn_mode  input  1  raw mode button, active-high, asynchronous to `clk`
- btn_inc  input  1  raw increment button, active-high, asynchronous to `clk`
- hours  output  5  0–23
- minutes  output  6  0–59
- seconds  output  6  0–59
- mode  output  2  current state encoding: RUN=0, SET_HH=1, SET_MM=2
- blank_hh  output  1  hours field blanked, for blinking
- blank_mm  output  1  minutes field blanked, for blinking

## Operation
- Buttons pass through a 2-flop synchronizer, then a debouncer, then a rising-edge detector. Each accepted press yields exactly one `clk`-wide internal pulse. A held button produces no repeat.
- FSM states, in order RUN → SET_HH → SET_MM → RUN, advance on each mode pulse.
- RUN:
  - on `tick_1hz`, seconds increments.
  - 59→0 carries into minutes; minutes 59→0 carries into hours; hours 23→0.
  - Increment pulses are ignored.
- SET_HH:
  - the time is frozen and `tick_1hz` is ignored.
  - an inc pulse increments hours modulo 24.
  - entering SET_HH clears seconds to 0.
- SET_MM:
  - the time is frozen.
  - an inc pulse increments minutes modulo 60, with no carry into hours.
- Leaving SET_MM for RUN: counting resumes at the next `tick_1hz`. Seconds stays 0 until then.
- Simultaneous events:
  - a mode pulse and an inc pulse in the same cycle: mode wins and the inc is dropped.
  - `tick_1hz` and a mode pulse in RUN in the same cycle: the tick is applied, then the state moves to SET_HH. Seconds is then cleared on the next cycle by the SET_HH entry rule.
- Reset asserted at any time, including mid-debounce or mid-set: all state returns to its reset value immediately.

## Timing
- Reset values:
  - hours=0, minutes=0, seconds=0
  - mode=RUN
  - blank_hh=0, blank_mm=0
  - debounce counters=0, synchronizer flops=0
- Time registers update on the `clk` edge where `tick_1hz` is sampled high, so `seconds` changes 1 cycle after the pulse.
- Button latency from a raw edge to the internal pulse: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge cycle. A pulse seen in cycle N changes the state or field at the N+1 edge.
- A glitch shorter than DEBOUNCE_CYCLES samples is rejected, and the debounce counter restarts.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- Macro: `CONTROL_RELOJ_BLINK_EN`.
- Defined:
  - a blink-phase flop toggles on each `tick_1hz`, in every state.
  - `blank_hh` = phase in SET_HH; `blank_mm` = phase in SET_MM; 0 otherwise.
  - the phase is cleared to 0 on every state change, so the field is visible immediately on entry.
- Undefined: the phase flop is not built, and `blank_hh`/`blank_mm` are tied to 0.

## Structure
- Package `reloj_pkg`:
  - `estado_t` enum (RUN, SET_HH, SET_MM, 2-bit)
  - constants MAX_HORAS=23, MAX_MINUTOS=59, MAX_SEGUNDOS=59
  - field widths 5/6/6
- Sub-module `antirrebote`: synchronizer + debouncer + rising-edge pulse, parameterized by DEBOUNCE_CYCLES. Instantiated twice, once per button.

## Test plan
- Reset released, 60 `tick_1hz` pulses → seconds goes 0→59→0, minutes=1, mode=0, all outputs 0 while reset is low.
- Preload via the set path to 23:59, return to RUN, 60 ticks → 00:00:00 after the 60th tick (hour and minute wrap).
- Mode press (held 20 cycles), then 25 inc presses → mode=1, seconds=0, hours=1 (25 mod 24). Ticks during this time leave the time unchanged.
- btn_inc glitch of 10 cycles with DEBOUNCE_CYCLES=16 → no increment. Button held 200 cycles → exactly one increment.
- Mode and inc pulses aligned in the same cycle in SET_HH → mode=2, hours unchanged. Reset asserted mid-SET_MM → mode=0 and time 00:00:00 asynchronously.
- With `CONTROL_RELOJ_BLINK_EN` defined, in SET_MM: blank_mm=0 on entry, toggles 1,0,1 on successive ticks, blank_hh stays 0. Without the macro, both stay 0 throughout.
